// File: rtl/cpu_mem_pkg.sv
// Shared encodings and defaults for the unified memory arbiter.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY_IF = 2'b01,
        ST_BUSY_D  = 2'b10
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_IF   = 2'b01,
        GNT_D    = 2'b10
    } grant_e;

    // A zero limit still needs a one-bit counter to keep the port legal.
    function automatic int starve_cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data wins ties; a saturating starvation counter forces a fetch after STARVE_LIMIT data wins.
module unified_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ready_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        grant_o
);

    localparam int                CNT_W   = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_e        state_q;
    grant_e            grant_q;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              mem_done;
    logic              data_wins;

    // A reset in the completion cycle abandons the access, so it must not pulse ready.
    assign mem_done   = mem_req_q && mem_ready_i && !reset_i;
    assign data_wins  = d_req_i && (!if_req_i || (starve_cnt_q < LIMIT_C));

    assign if_ready_o = mem_done && (state_q == ST_BUSY_IF);
    assign d_ready_o  = mem_done && (state_q == ST_BUSY_D);
    assign if_rdata_o = if_ready_o ? mem_rdata_i : if_rdata_q;
    assign d_rdata_o  = (d_ready_o && !mem_we_q) ? mem_rdata_i : d_rdata_q;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign grant_o     = grant_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_NONE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_wins) begin
                        state_q     <= ST_BUSY_D;
                        grant_q     <= GNT_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we_i;
                        mem_addr_q  <= d_addr_i;
                        mem_wdata_q <= d_wdata_i;
                        // Only wins over a waiting fetch count towards starvation.
                        if (if_req_i) begin
                            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
                        end
                    end else if (if_req_i) begin
                        state_q      <= ST_BUSY_IF;
                        grant_q      <= GNT_IF;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= if_addr_i;
                        starve_cnt_q <= '0;
                    end
                end
                ST_BUSY_IF, ST_BUSY_D: begin
                    if (mem_ready_i) begin
                        state_q   <= ST_IDLE;
                        grant_q   <= GNT_NONE;
                        mem_req_q <= 1'b0;
                        if (state_q == ST_BUSY_IF) begin
                            if_rdata_q <= mem_rdata_i;
                        end else if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata_i;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    grant_q   <= GNT_NONE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
